axil_reg_if_wr: RTL and testbench

// AXI4-lite write-side responder: joins AW and W, drives a simple register write port,

---
 rtl/axil_reg_if_wr.sv | 166 ++++++++++++++++
 tb/tb_axil_reg_if_wr.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_reg_if_wr.sv
// AXI4-lite write responder terminating at a simple CSR write port.
// AW and W are captured independently into holding registers. Once both are
// held, a single register write request is raised. It is held until the
// register block acks it, or until the timeout counter expires, which
// produces an SLVERR response.
module axil_reg_if_wr #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int TIMEOUT    = 4
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
    input  logic [2:0]            s_axil_awprot,
    input  logic                  s_axil_awvalid,
    output logic                  s_axil_awready,
    input  logic [DATA_WIDTH-1:0] s_axil_wdata,
    input  logic [STRB_WIDTH-1:0] s_axil_wstrb,
    input  logic                  s_axil_wvalid,
    output logic                  s_axil_wready,
    output logic [1:0]            s_axil_bresp,
    output logic                  s_axil_bvalid,
    input  logic                  s_axil_bready,

    output logic [ADDR_WIDTH-1:0] reg_wr_addr,
    output logic [DATA_WIDTH-1:0] reg_wr_data,
    output logic [STRB_WIDTH-1:0] reg_wr_strb,
    output logic                  reg_wr_en,
    input  logic                  reg_wr_wait,
    input  logic                  reg_wr_ack
);

    localparam int CNT_WIDTH = $clog2(TIMEOUT + 1);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_RESP
    } state_t;

    state_t                 state_reg, state_next;
    logic                   aw_held_reg, aw_held_next;
    logic                   w_held_reg, w_held_next;
    logic [CNT_WIDTH-1:0]   cnt_reg, cnt_next;
    logic [1:0]             bresp_reg, bresp_next;
    logic [ADDR_WIDTH-1:0]  addr_reg;
    logic [DATA_WIDTH-1:0]  data_reg;
    logic [STRB_WIDTH-1:0]  strb_reg;

    logic aw_hs;
    logic w_hs;

    // Protection bits carry no meaning for this register block.
    logic unused_awprot;
    assign unused_awprot = ^s_axil_awprot;

    // Each channel is accepted at most once per transaction.
    assign s_axil_awready = (state_reg == ST_IDLE) && !aw_held_reg;
    assign s_axil_wready  = (state_reg == ST_IDLE) && !w_held_reg;
    assign aw_hs          = s_axil_awvalid && s_axil_awready;
    assign w_hs           = s_axil_wvalid && s_axil_wready;

    assign s_axil_bvalid  = (state_reg == ST_RESP);
    assign s_axil_bresp   = bresp_reg;
    assign reg_wr_en      = (state_reg == ST_ACCESS);
    assign reg_wr_addr    = addr_reg;
    assign reg_wr_data    = data_reg;
    assign reg_wr_strb    = strb_reg;

    // Next-state logic: channel joining, ack/wait/timeout arbitration, B handshake.
    always_comb begin
        state_next   = state_reg;
        aw_held_next = aw_held_reg;
        w_held_next  = w_held_reg;
        cnt_next     = cnt_reg;
        bresp_next   = bresp_reg;
        unique case (state_reg)
            ST_IDLE: begin
                if (aw_hs) begin
                    aw_held_next = 1'b1;
                end
                if (w_hs) begin
                    w_held_next = 1'b1;
                end
                if ((aw_held_reg || aw_hs) && (w_held_reg || w_hs)) begin
                    state_next = ST_ACCESS;
                    cnt_next   = CNT_WIDTH'(TIMEOUT);
                end
            end
            ST_ACCESS: begin
                // Ack wins over wait and over a timeout expiring in the same cycle.
                if (reg_wr_ack) begin
                    state_next = ST_RESP;
                    bresp_next = RESP_OKAY;
                end else if (reg_wr_wait) begin
                    cnt_next = cnt_reg;
                end else if (cnt_reg == CNT_WIDTH'(1)) begin
                    state_next = ST_RESP;
                    bresp_next = RESP_SLVERR;
                end else begin
                    cnt_next = cnt_reg - CNT_WIDTH'(1);
                end
            end
            ST_RESP: begin
                if (s_axil_bready) begin
                    state_next   = ST_IDLE;
                    aw_held_next = 1'b0;
                    w_held_next  = 1'b0;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Control state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            aw_held_reg <= 1'b0;
            w_held_reg  <= 1'b0;
            cnt_reg     <= '0;
            bresp_reg   <= RESP_OKAY;
        end else begin
            state_reg   <= state_next;
            aw_held_reg <= aw_held_next;
            w_held_reg  <= w_held_next;
            cnt_reg     <= cnt_next;
            bresp_reg   <= bresp_next;
        end
    end

    // Address and strobe holding registers; only written while the channel is open.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_reg <= '0;
            strb_reg <= '0;
        end else begin
            if (aw_hs) begin
                addr_reg <= s_axil_awaddr;
            end
            if (w_hs) begin
                strb_reg <= s_axil_wstrb;
            end
        end
    end

    // Data holding register, one byte lane per generate iteration.
    generate
        for (genvar gi = 0; gi < STRB_WIDTH; gi++) begin : g_data_lane
            always_ff @(posedge clk) begin
                if (rst) begin
                    data_reg[gi*8 +: 8] <= 8'h00;
                end else if (w_hs) begin
                    data_reg[gi*8 +: 8] <= s_axil_wdata[gi*8 +: 8];
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_axil_reg_if_wr.sv
// Testbench for axil_reg_if_wr: directed scenarios plus randomized transactions
// compared against a cycle-counting model of the ack/wait/timeout rules.
module tb_axil_reg_if_wr;

    localparam int TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] s_axil_awaddr = '0;
    logic [2:0]  s_axil_awprot = '0;
    logic        s_axil_awvalid = 1'b0;
    logic        s_axil_awready;
    logic [31:0] s_axil_wdata = '0;
    logic [3:0]  s_axil_wstrb = '0;
    logic        s_axil_wvalid = 1'b0;
    logic        s_axil_wready;
    logic [1:0]  s_axil_bresp;
    logic        s_axil_bvalid;
    logic        s_axil_bready = 1'b0;
    logic [31:0] reg_wr_addr;
    logic [31:0] reg_wr_data;
    logic [3:0]  reg_wr_strb;
    logic        reg_wr_en;
    logic        reg_wr_wait = 1'b0;
    logic        reg_wr_ack = 1'b0;

    int checks   = 0;
    int failures = 0;

    axil_reg_if_wr #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(32),
        .STRB_WIDTH(4),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axil_awaddr (s_axil_awaddr),
        .s_axil_awprot (s_axil_awprot),
        .s_axil_awvalid(s_axil_awvalid),
        .s_axil_awready(s_axil_awready),
        .s_axil_wdata  (s_axil_wdata),
        .s_axil_wstrb  (s_axil_wstrb),
        .s_axil_wvalid (s_axil_wvalid),
        .s_axil_wready (s_axil_wready),
        .s_axil_bresp  (s_axil_bresp),
        .s_axil_bvalid (s_axil_bvalid),
        .s_axil_bready (s_axil_bready),
        .reg_wr_addr   (reg_wr_addr),
        .reg_wr_data   (reg_wr_data),
        .reg_wr_strb   (reg_wr_strb),
        .reg_wr_en     (reg_wr_en),
        .reg_wr_wait   (reg_wr_wait),
        .reg_wr_ack    (reg_wr_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          en_n;       // cycles with reg_wr_en high
        int          en_lat;     // cycles from final AW/W handshake to first reg_wr_en
        int          bv_lat;     // cycles from final AW/W handshake to first bvalid
        int          resp_cyc;   // cycles with bvalid high
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  resp;
        bit          en_stable;
        bit          b_stable;
        bit          ready_leak; // a channel was ready again before B completed
        bit          ready_back; // both readies high, bvalid/en low right after B
        bit          timed_out;
    } obs_t;

    // Reference: walk the request cycle by cycle using the ack > wait > countdown rules.
    function automatic void model(input int wait_n, input int ack_idx,
                                  output int exp_en, output logic [1:0] exp_resp);
        int budget;
        budget   = TIMEOUT;
        exp_en   = 0;
        exp_resp = 2'b00;
        for (int i = 1; i < 1000; i++) begin
            if (i == ack_idx) begin
                exp_en   = i;
                exp_resp = 2'b00;
                return;
            end
            if (i > wait_n) begin
                budget--;
                if (budget == 0) begin
                    exp_en   = i;
                    exp_resp = 2'b10;
                    return;
                end
            end
        end
    endfunction

    // Drives one write: AW/W after their delays, wait for the first wait_n request
    // cycles, ack on request cycle ack_idx (0 = never), bready after bready_dly cycles.
    task automatic run_txn(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int aw_dly, input int w_dly,
                           input int wait_n, input int ack_idx, input int bready_dly,
                           output obs_t o);
        int cyc;
        int hs_cyc;
        int en_cnt;
        int resp_cnt;
        bit aw_done;
        bit w_done;
        bit b_done;
        o.en_n = 0; o.en_lat = -1; o.bv_lat = -1; o.resp_cyc = 0;
        o.addr = '0; o.data = '0; o.strb = '0; o.resp = 2'b00;
        o.en_stable = 1'b1; o.b_stable = 1'b1; o.ready_leak = 1'b0;
        o.ready_back = 1'b0; o.timed_out = 1'b0;
        cyc = 0; hs_cyc = -1; en_cnt = 0; resp_cnt = 0;
        aw_done = 1'b0; w_done = 1'b0; b_done = 1'b0;
        while (!b_done && cyc < 300) begin
            @(posedge clk); #1;
            if (reg_wr_en) begin
                en_cnt++;
                if (en_cnt == 1) begin
                    o.addr   = reg_wr_addr;
                    o.data   = reg_wr_data;
                    o.strb   = reg_wr_strb;
                    o.en_lat = cyc - hs_cyc;
                end else if (reg_wr_addr !== o.addr || reg_wr_data !== o.data ||
                             reg_wr_strb !== o.strb) begin
                    o.en_stable = 1'b0;
                end
            end
            if ((aw_done && s_axil_awready) || (w_done && s_axil_wready)) begin
                o.ready_leak = 1'b1;
            end
            if (s_axil_bvalid) begin
                if (resp_cnt == 0) begin
                    o.resp   = s_axil_bresp;
                    o.bv_lat = cyc - hs_cyc;
                end else if (s_axil_bresp !== o.resp) begin
                    o.b_stable = 1'b0;
                end
                resp_cnt++;
            end
            s_axil_awvalid = !aw_done && (cyc >= aw_dly);
            s_axil_awaddr  = s_axil_awvalid ? addr : $urandom;
            s_axil_awprot  = 3'($urandom);
            s_axil_wvalid  = !w_done && (cyc >= w_dly);
            s_axil_wdata   = s_axil_wvalid ? data : $urandom;
            s_axil_wstrb   = s_axil_wvalid ? strb : 4'($urandom);
            reg_wr_wait    = reg_wr_en && (en_cnt <= wait_n);
            reg_wr_ack     = reg_wr_en && (en_cnt == ack_idx);
            s_axil_bready  = s_axil_bvalid && (resp_cnt > bready_dly);
            if (s_axil_awvalid && s_axil_awready) aw_done = 1'b1;
            if (s_axil_wvalid && s_axil_wready) w_done = 1'b1;
            if (hs_cyc < 0 && aw_done && w_done) hs_cyc = cyc;
            if (s_axil_bvalid && s_axil_bready) b_done = 1'b1;
            cyc++;
        end
        o.timed_out = !b_done;
        o.en_n      = en_cnt;
        o.resp_cyc  = resp_cnt;
        @(posedge clk); #1;
        o.ready_back = s_axil_awready && s_axil_wready && !s_axil_bvalid && !reg_wr_en;
        s_axil_awvalid = 1'b0;
        s_axil_wvalid  = 1'b0;
        s_axil_bready  = 1'b0;
        reg_wr_wait    = 1'b0;
        reg_wr_ack     = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (reg_wr_en !== 1'b0 || s_axil_bvalid !== 1'b0 || s_axil_bresp !== 2'b00) begin
            failures++;
            $display("FAIL reset_outputs: en=%b bvalid=%b bresp=%b, required en=0 bvalid=0 bresp=00",
                     reg_wr_en, s_axil_bvalid, s_axil_bresp);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (s_axil_awready !== 1'b1 || s_axil_wready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready: awready=%b wready=%b, required 1 1",
                     s_axil_awready, s_axil_wready);
        end
        $display("txn reset: awready=%b wready=%b", s_axil_awready, s_axil_wready);
    endtask

    task automatic test_same_cycle();
        obs_t o;
        run_txn(32'h10, 32'hDEADBEEF, 4'hF, 0, 0, 0, 1, 0, o);
        $display("txn same_cycle: en_n=%0d addr=%h data=%h strb=%h bv_lat=%0d resp=%b",
                 o.en_n, o.addr, o.data, o.strb, o.bv_lat, o.resp);
        checks++;
        if (o.en_n !== 1) begin
            failures++; $display("FAIL same_cycle_en_len: got %0d, required 1", o.en_n);
        end
        checks++;
        if (o.addr !== 32'h10 || o.data !== 32'hDEADBEEF || o.strb !== 4'hF) begin
            failures++;
            $display("FAIL same_cycle_values: got %h/%h/%h, required 00000010/deadbeef/f",
                     o.addr, o.data, o.strb);
        end
        checks++;
        if (o.bv_lat !== 2 || o.resp !== 2'b00) begin
            failures++;
            $display("FAIL same_cycle_b: lat=%0d resp=%b, required lat=2 resp=00", o.bv_lat, o.resp);
        end
        checks++;
        if (o.ready_back !== 1'b1) begin
            failures++; $display("FAIL same_cycle_ready_back: got 0, required 1");
        end
    endtask

    task automatic test_w_before_aw();
        obs_t o;
        run_txn(32'h20, 32'h12345678, 4'hF, 3, 0, 0, 1, 0, o);
        $display("txn w_before_aw: en_lat=%0d addr=%h data=%h resp=%b leak=%b",
                 o.en_lat, o.addr, o.data, o.resp, o.ready_leak);
        checks++;
        if (o.ready_leak !== 1'b0) begin
            failures++; $display("FAIL w_first_wready_low: wready reasserted early, required low");
        end
        checks++;
        if (o.en_lat !== 1) begin
            failures++; $display("FAIL w_first_en_lat: got %0d, required 1", o.en_lat);
        end
        checks++;
        if (o.addr !== 32'h20 || o.data !== 32'h12345678 || o.resp !== 2'b00) begin
            failures++;
            $display("FAIL w_first_pairing: got %h/%h resp=%b, required 00000020/12345678 resp=00",
                     o.addr, o.data, o.resp);
        end
    endtask

    task automatic test_timeout();
        obs_t o;
        run_txn(32'h30, 32'hA5A5_5A5A, 4'h3, 0, 1, 0, 0, 0, o);
        $display("txn timeout: en_n=%0d bv_lat=%0d resp=%b", o.en_n, o.bv_lat, o.resp);
        checks++;
        if (o.en_n !== TIMEOUT) begin
            failures++; $display("FAIL timeout_en_len: got %0d, required %0d", o.en_n, TIMEOUT);
        end
        checks++;
        if (o.resp !== 2'b10 || o.bv_lat !== TIMEOUT + 1) begin
            failures++;
            $display("FAIL timeout_b: resp=%b lat=%0d, required resp=10 lat=%0d",
                     o.resp, o.bv_lat, TIMEOUT + 1);
        end
        checks++;
        if (o.ready_back !== 1'b1) begin
            failures++; $display("FAIL timeout_ready_back: got 0, required 1");
        end
    endtask

    task automatic test_wait_stretch();
        obs_t o;
        run_txn(32'h44, 32'h0BAD_F00D, 4'hC, 1, 0, 10, 11, 0, o);
        $display("txn wait_stretch: en_n=%0d resp=%b stable=%b", o.en_n, o.resp, o.en_stable);
        checks++;
        if (o.en_n !== 11 || o.resp !== 2'b00) begin
            failures++;
            $display("FAIL wait_stretch: en_n=%0d resp=%b, required en_n=11 resp=00", o.en_n, o.resp);
        end
        checks++;
        if (o.en_stable !== 1'b1) begin
            failures++; $display("FAIL wait_stretch_stable: reg_wr_* changed, required stable");
        end
    endtask

    task automatic test_bready_hold();
        obs_t o;
        run_txn(32'h58, 32'hCAFE_0001, 4'h1, 0, 0, 0, 2, 5, o);
        $display("txn bready_hold: resp_cyc=%0d resp=%b stable=%b leak=%b back=%b",
                 o.resp_cyc, o.resp, o.b_stable, o.ready_leak, o.ready_back);
        checks++;
        if (o.resp_cyc !== 6 || o.b_stable !== 1'b1 || o.resp !== 2'b00) begin
            failures++;
            $display("FAIL bready_hold_b: cyc=%0d stable=%b resp=%b, required cyc=6 stable=1 resp=00",
                     o.resp_cyc, o.b_stable, o.resp);
        end
        checks++;
        if (o.ready_leak !== 1'b0 || o.ready_back !== 1'b1) begin
            failures++;
            $display("FAIL bready_hold_ready: leak=%b back=%b, required leak=0 back=1",
                     o.ready_leak, o.ready_back);
        end
    endtask

    task automatic test_reset_mid();
        obs_t o;
        bit   saw_b;
        @(posedge clk); #1;
        s_axil_awaddr  = 32'h64;
        s_axil_wdata   = 32'h1111_2222;
        s_axil_wstrb   = 4'hF;
        s_axil_awvalid = 1'b1;
        s_axil_wvalid  = 1'b1;
        @(posedge clk); #1;
        s_axil_awvalid = 1'b0;
        s_axil_wvalid  = 1'b0;
        reg_wr_wait    = 1'b1;
        checks++;
        if (reg_wr_en !== 1'b1) begin
            failures++; $display("FAIL reset_mid_en_before: got %b, required 1", reg_wr_en);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        reg_wr_wait = 1'b0;
        checks++;
        if (reg_wr_en !== 1'b0 || s_axil_bvalid !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_abort: en=%b bvalid=%b, required 0 0", reg_wr_en, s_axil_bvalid);
        end
        saw_b = 1'b0;
        s_axil_bready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (s_axil_bvalid || reg_wr_en) saw_b = 1'b1;
        end
        s_axil_bready = 1'b0;
        checks++;
        if (saw_b !== 1'b0) begin
            failures++; $display("FAIL reset_mid_no_b: activity after reset, required none");
        end
        run_txn(32'h68, 32'h3333_4444, 4'h5, 0, 0, 1, 2, 0, o);
        $display("txn reset_mid_next: addr=%h data=%h resp=%b", o.addr, o.data, o.resp);
        checks++;
        if (o.resp !== 2'b00 || o.addr !== 32'h68 || o.data !== 32'h3333_4444 || o.timed_out) begin
            failures++;
            $display("FAIL reset_mid_next: got %h/%h resp=%b to=%b, required 00000068/33334444 resp=00",
                     o.addr, o.data, o.resp, o.timed_out);
        end
    endtask

    task automatic test_random();
        obs_t        o;
        logic [31:0] addr, data;
        logic [3:0]  strb;
        int          aw_dly, w_dly, wait_n, ack_idx, bready_dly, exp_en;
        logic [1:0]  exp_resp;
        for (int t = 0; t < 24; t++) begin
            addr       = $urandom;
            data       = $urandom;
            strb       = 4'($urandom_range(0, 15));
            aw_dly     = $urandom_range(0, 3);
            w_dly      = $urandom_range(0, 3);
            wait_n     = $urandom_range(0, 6);
            ack_idx    = $urandom_range(0, 9);
            bready_dly = $urandom_range(0, 3);
            model(wait_n, ack_idx, exp_en, exp_resp);
            run_txn(addr, data, strb, aw_dly, w_dly, wait_n, ack_idx, bready_dly, o);
            $display("txn random %0d: addr=%h data=%h strb=%h wait=%0d ack=%0d en_n=%0d/%0d resp=%b/%b",
                     t, addr, data, strb, wait_n, ack_idx, o.en_n, exp_en, o.resp, exp_resp);
            checks++;
            if (o.timed_out || o.en_n !== exp_en || o.resp !== exp_resp || o.bv_lat !== exp_en + 1) begin
                failures++;
                $display("FAIL random_%0d_resp: en_n=%0d resp=%b lat=%0d, required en_n=%0d resp=%b lat=%0d",
                         t, o.en_n, o.resp, o.bv_lat, exp_en, exp_resp, exp_en + 1);
            end
            checks++;
            if (o.addr !== addr || o.data !== data || o.strb !== strb || o.en_stable !== 1'b1 ||
                o.en_lat !== 1) begin
                failures++;
                $display("FAIL random_%0d_port: %h/%h/%h stable=%b lat=%0d, required %h/%h/%h stable=1 lat=1",
                         t, o.addr, o.data, o.strb, o.en_stable, o.en_lat, addr, data, strb);
            end
            checks++;
            if (o.ready_leak !== 1'b0 || o.ready_back !== 1'b1 || o.b_stable !== 1'b1 ||
                o.resp_cyc !== bready_dly + 1) begin
                failures++;
                $display("FAIL random_%0d_chan: leak=%b back=%b bstable=%b bcyc=%0d, required 0 1 1 %0d",
                         t, o.ready_leak, o.ready_back, o.b_stable, o.resp_cyc, bready_dly + 1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_same_cycle();
        test_w_before_aw();
        test_timeout();
        test_wait_stretch();
        test_bready_hold();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

endmodule
